i2s_tx_sync: RTL and testbench

- I2S transmitter that runs entirely in the system clock domain and drives DACDAT to the WM8731 codec.
- The codec is bus master: it drives BCLK and DACLRC, and the block oversamples both with clk.
- Processed stereo samples arrive from the effect chain on a valid/ready handshake into a one-frame holding buffer.
- It is the transmit counterpart of the codec_in receiver and sits between the effect stage and the codec pins.

---
 rtl/i2s_tx_sync.sv | 189 ++++++++++++++++++
 tb/tb_i2s_tx_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sync.sv
// I2S transmitter in the system clock domain: oversamples codec BCLK/DACLRC and shifts stereo words out on DACDAT.
// Optional build macro I2S_TX_HOLD_LAST_EN: on underrun, repeat the previous pair instead of sending zeros.
`timescale 1ns/1ps
module i2s_tx_sync #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  BCLK,
  input  logic                  DACLRC,
  output logic                  DACDAT,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  frame_start,
  output logic                  underrun,
  output logic [1:0]            o_dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lrc_sync;
  logic                   r_bclk_hist;
  logic                   r_lrc_q;

  logic [DATA_WIDTH-1:0]  r_pend_left, r_pend_right;
  logic                   r_pend_full;
  logic [DATA_WIDTH-1:0]  r_act_left, r_act_right;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_dacdat;
  logic                   r_frame_start;
  logic                   r_underrun;

  logic                   w_bclk_s, w_lrc_s, w_bclk_fall;
  logic                   w_left_start, w_right_start, w_chan_edge;
  logic                   w_xfer, w_underrun;
  logic [DATA_WIDTH-1:0]  w_commit_left, w_commit_right;
  logic                   w_load, w_shift;

  // Handshake: a pair moves when in_valid && in_ready on a rising clk edge; in_ready is high
  // whenever the one-pair holding buffer is empty, and in_valid/data must hold until accepted.
  assign in_ready    = !r_pend_full;
  assign w_xfer      = in_valid && in_ready;
  assign DACDAT      = r_dacdat;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;

  assign w_bclk_s      = r_bclk_sync[SYNC_STAGES-1];
  assign w_lrc_s       = r_lrc_sync[SYNC_STAGES-1];
  assign w_bclk_fall   = r_bclk_hist && !w_bclk_s;
  assign w_left_start  = w_bclk_fall && r_lrc_q && !w_lrc_s;
  assign w_right_start = w_bclk_fall && !r_lrc_q && w_lrc_s;
  assign w_chan_edge   = w_left_start || w_right_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_sync <= '0;
      r_lrc_sync  <= '0;
      r_bclk_hist <= 1'b0;
      r_lrc_q     <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], BCLK};
      r_lrc_sync  <= {r_lrc_sync[SYNC_STAGES-2:0], DACLRC};
      r_bclk_hist <= w_bclk_s;
      if (w_bclk_fall) r_lrc_q <= w_lrc_s;
    end
  end

  // Pair that becomes active at a left start: buffered, bypassed, or underrun fill.
  always_comb begin
    w_commit_left  = r_act_left;
    w_commit_right = r_act_right;
    w_underrun     = 1'b0;
    if (r_pend_full) begin
      w_commit_left  = r_pend_left;
      w_commit_right = r_pend_right;
    end else if (w_xfer) begin
      w_commit_left  = in_left;
      w_commit_right = in_right;
    end else begin
      w_underrun = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
      w_commit_left  = r_act_left;
      w_commit_right = r_act_right;
`else
      w_commit_left  = '0;
      w_commit_right = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_left   <= '0;
      r_pend_right  <= '0;
      r_pend_full   <= 1'b0;
      r_act_left    <= '0;
      r_act_right   <= '0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_left_start;
      r_underrun    <= w_left_start && w_underrun;
      if (w_left_start) begin
        r_act_left  <= w_commit_left;
        r_act_right <= w_commit_right;
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pend_left  <= in_left;
        r_pend_right <= in_right;
        r_pend_full  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_left_start) begin
          w_state_nxt = ST_ARM;
          w_load      = 1'b1;
        end
      end
      ST_ARM: begin
        if (w_chan_edge)      w_load      = 1'b1;
        else if (w_bclk_fall) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_chan_edge) begin
          w_state_nxt = ST_ARM;
          w_load      = 1'b1;
        end else if (w_bclk_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_LAST) w_state_nxt = ST_PAD;
        end
      end
      ST_PAD: begin
        if (w_chan_edge) begin
          w_state_nxt = ST_ARM;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // DACDAT only moves on a bclk_fall cycle so it is settled by the codec's BCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_dacdat  <= 1'b0;
    end else begin
      if (w_load) begin
        r_shreg   <= w_left_start ? w_commit_left : r_act_right;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
        if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_bclk_fall) r_dacdat <= w_shift ? r_shreg[DATA_WIDTH-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sync.sv
// Directed bench for i2s_tx_sync: the bench plays the codec (BCLK = clk/16) and captures DACDAT on BCLK rise.
`timescale 1ns/1ps
module tb_i2s_tx_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        BCLK;
  logic        DACLRC;
  logic        DACDAT;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_left;
  logic [23:0] in_right;
  logic        frame_start;
  logic        underrun;
  logic [1:0]  dbg_state;

  int          n_vec  = 0;
  int          n_fail = 0;
  int          fs_cnt = 0;
  int          ur_cnt = 0;
  logic [47:0] exp_q[$];
  logic        bp_run;
  int          bp_seq;

  i2s_tx_sync #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .BCLK        (BCLK),
    .DACLRC      (DACLRC),
    .DACDAT      (DACDAT),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .frame_start (frame_start),
    .underrun    (underrun),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (underrun)    ur_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // one codec channel of nb BCLK periods; optional pulse of in_valid on the commit clk
  task automatic run_channel(input logic lrc, input int nb, input logic byp,
                             input logic [23:0] bl, input logic [23:0] br,
                             output logic [31:0] cap);
    cap = '0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      BCLK = 1'b0;
      if (i == 0) DACLRC = lrc;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        if (byp && i == 0 && k == 1) begin
          in_valid = 1'b1;
          in_left  = bl;
          in_right = br;
        end
        if (byp && i == 0 && k == 2) in_valid = 1'b0;
      end
      @(negedge clk);
      BCLK = 1'b1;
      cap  = {cap[30:0], DACDAT};
      for (int k = 0; k < 7; k++) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int nb, input logic byp, input logic [23:0] bl, input logic [23:0] br,
                           output logic [31:0] capl, output logic [31:0] capr);
    run_channel(1'b0, nb, byp, bl, br, capl);
    run_channel(1'b1, nb, 1'b0, 24'h0, 24'h0, capr);
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {47'h0, in_ready}, 48'h1);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        push;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic        exp_ur;
  } frame_vec_t;

  frame_vec_t  vec[6];
  logic [31:0] cap_l, cap_r;
  int          fs0, ur0;

  initial begin
    vec[0] = '{push: 1'b1, l: 24'hA5A5A5, r: 24'h3C3C3C, exp_l: 24'hA5A5A5, exp_r: 24'h3C3C3C, exp_ur: 1'b0};
    vec[1] = '{push: 1'b1, l: 24'h123456, r: 24'hFEDCBA, exp_l: 24'h123456, exp_r: 24'hFEDCBA, exp_ur: 1'b0};
    vec[2] = '{push: 1'b1, l: 24'h800001, r: 24'h7FFFFE, exp_l: 24'h800001, exp_r: 24'h7FFFFE, exp_ur: 1'b0};
`ifdef I2S_TX_HOLD_LAST_EN
    vec[3] = '{push: 1'b0, l: 24'h0,      r: 24'h0,      exp_l: 24'h800001, exp_r: 24'h7FFFFE, exp_ur: 1'b1};
`else
    vec[3] = '{push: 1'b0, l: 24'h0,      r: 24'h0,      exp_l: 24'h000000, exp_r: 24'h000000, exp_ur: 1'b1};
`endif
    vec[4] = '{push: 1'b1, l: 24'hFFFFFF, r: 24'h000000, exp_l: 24'hFFFFFF, exp_r: 24'h000000, exp_ur: 1'b0};
    vec[5] = '{push: 1'b1, l: 24'h000001, r: 24'h800000, exp_l: 24'h000001, exp_r: 24'h800000, exp_ur: 1'b0};

    rst_n    = 1'b0;
    BCLK     = 1'b1;
    DACLRC   = 1'b1;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    bp_run   = 1'b0;
    bp_seq   = 0;
    repeat (3) @(negedge clk);
    check("rst_dacdat",      {47'h0, DACDAT},      48'h0);
    check("rst_in_ready",    {47'h0, in_ready},    48'h1);
    check("rst_frame_start", {47'h0, frame_start}, 48'h0);
    check("rst_underrun",    {47'h0, underrun},    48'h0);
    check("rst_state",       {46'h0, dbg_state},   48'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // startup with DACLRC high: a right-start edge must not wake the transmitter
    run_channel(1'b1, 32, 1'b0, 24'h0, 24'h0, cap_r);
    check("startup_dacdat", {16'h0, cap_r}, 48'h0);
    check("startup_state",  {46'h0, dbg_state}, 48'h0);

    for (int i = 0; i < 6; i++) begin
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      if (vec[i].push) push_pair(vec[i].l, vec[i].r);
      run_frame(32, 1'b0, 24'h0, 24'h0, cap_l, cap_r);
      check($sformatf("v%0d_left", i),  {24'h0, cap_l[29:6]}, {24'h0, vec[i].exp_l});
      check($sformatf("v%0d_right", i), {24'h0, cap_r[29:6]}, {24'h0, vec[i].exp_r});
      check($sformatf("v%0d_lpad", i),  {40'h0, cap_l[31:30], cap_l[5:0]}, 48'h0);
      check($sformatf("v%0d_rpad", i),  {40'h0, cap_r[31:30], cap_r[5:0]}, 48'h0);
      check($sformatf("v%0d_fs", i),    48'(fs_cnt - fs0), 48'd1);
      check($sformatf("v%0d_ur", i),    48'(ur_cnt - ur0), {47'h0, vec[i].exp_ur});
      if (!vec[i].push) check($sformatf("v%0d_ready", i), {47'h0, in_ready}, 48'h1);
    end

    // bypass: pair offered on the exact commit clk with the buffer empty
    fs0 = fs_cnt;
    ur0 = ur_cnt;
    run_frame(32, 1'b1, 24'h5A5A5A, 24'hC3C3C3, cap_l, cap_r);
    check("byp_left",  {24'h0, cap_l[29:6]}, 48'h5A5A5A);
    check("byp_right", {24'h0, cap_r[29:6]}, 48'hC3C3C3);
    check("byp_fs",    48'(fs_cnt - fs0), 48'd1);
    check("byp_ur",    48'(ur_cnt - ur0), 48'd0);
    check("byp_ready", {47'h0, in_ready}, 48'h1);

    // short frames: 16 BCLK per channel leaves room for the top 14 bits only
    push_pair(24'hDEADBE, 24'h13579B);
    run_frame(16, 1'b0, 24'h0, 24'h0, cap_l, cap_r);
    check("short1_left",  {32'h0, cap_l[15:0]}, {34'h0, 14'(24'hDEADBE >> 10)});
    check("short1_right", {32'h0, cap_r[15:0]}, {34'h0, 14'(24'h13579B >> 10)});
    push_pair(24'h2468AC, 24'hFEDCBA);
    run_frame(16, 1'b0, 24'h0, 24'h0, cap_l, cap_r);
    check("short2_left",  {32'h0, cap_l[15:0]}, {34'h0, 14'(24'h2468AC >> 10)});
    check("short2_right", {32'h0, cap_r[15:0]}, {34'h0, 14'(24'hFEDCBA >> 10)});

    // backpressure: producer offers a fresh pair every clk for 10 frames
    ur0    = ur_cnt;
    bp_run = 1'b1;
    fork
      begin
        while (bp_run) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_left  = {4'hF, bp_seq[19:0]};
          in_right = {4'h3, bp_seq[19:0] ^ 20'hAAAAA};
          bp_seq++;
          if (in_ready) exp_q.push_back({in_left, in_right});
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int f = 0; f < 10; f++) begin
          logic [47:0] e;
          run_frame(32, 1'b0, 24'h0, 24'h0, cap_l, cap_r);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
          check($sformatf("bp%0d_left", f),  {24'h0, cap_l[29:6]}, {24'h0, e[47:24]});
          check($sformatf("bp%0d_right", f), {24'h0, cap_r[29:6]}, {24'h0, e[23:0]});
        end
        bp_run = 1'b0;
      end
    join
    check("bp_left_over", 48'(exp_q.size()), 48'd1);
    check("bp_ready_low", {47'h0, in_ready}, 48'h0);
    check("bp_ur",        48'(ur_cnt - ur0), 48'd0);

    // reset in the middle of a left word (buffered pair has top nibble F)
    run_channel(1'b0, 5, 1'b0, 24'h0, 24'h0, cap_l);
    check("pre_rst_dacdat", {47'h0, DACDAT}, {47'h0, exp_q[0][45]});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dacdat",   {47'h0, DACDAT},      48'h0);
    check("mid_rst_in_ready", {47'h0, in_ready},    48'h1);
    check("mid_rst_state",    {46'h0, dbg_state},   48'h0);
    check("mid_rst_fs",       {47'h0, frame_start}, 48'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_state", {46'h0, dbg_state}, 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
